// File: rtl/picomips_gen2.sv
// picoMips second-generation accumulator core: FETCH/DECODE/EXEC sequencer with an
// external synchronous-read program ROM, optional saturating arithmetic and a sticky overflow flag.
module picomips_gen2 #(
    parameter int DATA_W   = 8,
    parameter int FRAC_W   = 2,
    parameter int REG_AW   = 1,
    parameter int PC_W     = 5,
    parameter int OPND_W   = 5,
    parameter bit SATURATE = 1'b1
) (
    input  logic              Clock,
    input  logic              nReset,
    output logic [PC_W-1:0]   prog_addr,
    input  logic [OPND_W+3:0] prog_data,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              sw_go,
    output logic [DATA_W-1:0] led,
    output logic              ovf,
    output logic              halted,
    output logic              retire
);

    localparam logic [3:0] OP_HEI  = 4'd1;
    localparam logic [3:0] OP_LSW  = 4'd2;
    localparam logic [3:0] OP_RTA  = 4'd3;
    localparam logic [3:0] OP_ATR  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_MULI = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_BNZ  = 4'd11;
    localparam logic [3:0] OP_BNEG = 4'd12;
    localparam logic [3:0] OP_OUT  = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd14;

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    state_t                   state, state_nxt;
    logic [PC_W-1:0]          pc;
    logic [OPND_W+3:0]        ir;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] reg_data;
    logic signed [DATA_W-1:0] regs [2**REG_AW];
    logic                     go_m, go_s;

    logic [3:0]               op;
    logic [OPND_W-1:0]        opnd;
    logic signed [OPND_W-1:0] opnd_s;
    logic signed [DATA_W-1:0] imm;
    logic                     hei_wait, take_br;
    logic                     arith, acc_we, ovf_hit;
    logic signed [DATA_W-1:0] acc_nxt;
    logic signed [2*DATA_W-1:0] wide;
    logic [DATA_W:0]          fitted;

    // Add/subtract one bit wider than the operands, returned sign-extended to 2*DATA_W.
    function automatic logic signed [2*DATA_W-1:0] add_w(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b,
                                                         input logic sub);
        logic signed [DATA_W:0] s;
        s = sub ? ((DATA_W+1)'(a) - (DATA_W+1)'(b)) : ((DATA_W+1)'(a) + (DATA_W+1)'(b));
        return (2*DATA_W)'(s);
    endfunction

    // Full-width fixed-point product; >>> truncates toward minus infinity.
    function automatic logic signed [2*DATA_W-1:0] mul_w(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return p >>> FRAC_W;
    endfunction

    // Returns {overflow, result}: clamps or wraps when the upper bits are not pure sign.
    function automatic logic [DATA_W:0] fit(input logic signed [2*DATA_W-1:0] v);
        if ((&v[2*DATA_W-1:DATA_W-1]) || !(|v[2*DATA_W-1:DATA_W-1]))
            return {1'b0, v[DATA_W-1:0]};
        else if (SATURATE)
            return {1'b1, v[2*DATA_W-1], {(DATA_W-1){~v[2*DATA_W-1]}}};
        else
            return {1'b1, v[DATA_W-1:0]};
    endfunction

    assign op        = ir[OPND_W+3:OPND_W];
    assign opnd      = ir[OPND_W-1:0];
    assign opnd_s    = ir[OPND_W-1:0];
    assign imm       = DATA_W'(opnd_s);
    assign prog_addr = pc;
    assign hei_wait  = (op == OP_HEI) && (go_s != opnd[0]);
    assign take_br   = (op == OP_JMP) ||
                       ((op == OP_BNZ) && (acc != '0)) ||
                       ((op == OP_BNEG) && acc[DATA_W-1]);

    always_comb begin
        arith   = 1'b0;
        acc_we  = 1'b0;
        acc_nxt = acc;
        wide    = '0;
        case (op)
            OP_LSW:  begin acc_we = 1'b1; acc_nxt = sw_in;    end
            OP_RTA:  begin acc_we = 1'b1; acc_nxt = reg_data; end
            OP_ADD:  begin arith = 1'b1; wide = add_w(acc, reg_data, 1'b0); end
            OP_ADDI: begin arith = 1'b1; wide = add_w(acc, imm, 1'b0);      end
            OP_SUB:  begin arith = 1'b1; wide = add_w(acc, reg_data, 1'b1); end
            OP_MULI: begin arith = 1'b1; wide = mul_w(acc, imm);            end
            OP_MUL:  begin arith = 1'b1; wide = mul_w(acc, reg_data);       end
            default: ;
        endcase
        fitted = fit(wide);
        if (arith) begin
            acc_we  = 1'b1;
            acc_nxt = fitted[DATA_W-1:0];
        end
        ovf_hit = arith && fitted[DATA_W];
    end

    // go handshake synchroniser
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            go_m <= 1'b0;
            go_s <= 1'b0;
        end else begin
            go_m <= sw_go;
            go_s <= go_m;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) state <= S_FETCH;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (op == OP_HALT)  state_nxt = S_HALT;
                else if (!hei_wait) state_nxt = S_FETCH;
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        retire = (state == S_EXEC) && !hei_wait;
        halted = (state == S_HALT);
    end

    // Datapath: ROM word latched in DECODE, effects committed at the end of EXEC
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc       <= '0;
            ir       <= '0;
            acc      <= '0;
            reg_data <= '0;
            led      <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else begin
            if (state == S_DECODE) begin
                ir       <= prog_data;
                reg_data <= regs[prog_data[REG_AW-1:0]];
            end
            if (state == S_EXEC) begin
                if (acc_we)        acc <= acc_nxt;
                if (ovf_hit)       ovf <= 1'b1;
                if (op == OP_OUT)  led <= acc;
                if (op == OP_ATR)  regs[ir[REG_AW-1:0]] <= acc;
                if (take_br)
                    pc <= opnd[PC_W-1:0];
                else if (!hei_wait && (op != OP_HALT))
                    pc <= pc + PC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_picomips_gen2.sv
// Directed bench for picomips_gen2: a default core (saturating, 32-word ROM) and a
// wrapping core with an 8-word ROM run side by side from a shared clock and reset.
module tb_picomips_gen2;

    localparam int OP_NOP = 0, OP_HEI = 1, OP_LSW = 2, OP_RTA = 3, OP_ATR = 4, OP_ADD = 5;
    localparam int OP_ADDI = 6, OP_SUB = 7, OP_MULI = 8, OP_MUL = 9, OP_JMP = 10;
    localparam int OP_BNZ = 11, OP_BNEG = 12, OP_OUT = 13, OP_HALT = 14;

    logic       clk = 1'b0;
    logic       nReset;
    logic [8:0] rom_a [0:31];
    logic [8:0] rom_b [0:7];
    logic [8:0] pd_a, pd_b;
    logic [4:0] pa_a;
    logic [2:0] pa_b;
    logic [7:0] sw_a, sw_b, led_a, led_b;
    logic       go_a, go_b, ovf_a, ovf_b, halted_a, halted_b, ret_a, ret_b;

    int n_chk = 0, n_err = 0, cyc_n = 0, rc_a = 0, rc_b = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pd_a <= rom_a[pa_a];
        pd_b <= rom_b[pa_b];
    end

    picomips_gen2 u_sat (
        .Clock(clk), .nReset(nReset), .prog_addr(pa_a), .prog_data(pd_a),
        .sw_in(sw_a), .sw_go(go_a), .led(led_a), .ovf(ovf_a),
        .halted(halted_a), .retire(ret_a)
    );

    picomips_gen2 #(.PC_W(3), .SATURATE(1'b0)) u_wrap (
        .Clock(clk), .nReset(nReset), .prog_addr(pa_b), .prog_data(pd_b),
        .sw_in(sw_b), .sw_go(go_b), .led(led_b), .ovf(ovf_b),
        .halted(halted_b), .retire(ret_b)
    );

    function automatic logic [8:0] ins(input int op, input int opnd);
        return {op[3:0], opnd[4:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task cyc();
        @(negedge clk);
        cyc_n++;
        if (ret_a) rc_a++;
        if (ret_b) rc_b++;
    endtask

    task go_to(input int c);
        while (cyc_n < c) cyc();
    endtask

    task fill();
        for (int i = 0; i < 32; i++) rom_a[i] = ins(OP_HALT, 0);
        for (int i = 0; i < 8; i++)  rom_b[i] = ins(OP_HALT, 0);
    endtask

    // Cycle 0 is the half-period between release and the first rising edge.
    task restart();
        nReset = 1'b0;
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        cyc_n = 0;
        rc_a = 0;
        rc_b = 0;
    endtask

    initial begin
        int bad;
        int k;
        nReset = 1'b0;
        sw_a = '0; sw_b = '0; go_a = 1'b0; go_b = 1'b0;
        fill();
        repeat (2) @(negedge clk);
        chk("rst_addr", pa_a, 0);
        chk("rst_led", led_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_halted", halted_a, 0);
        chk("rst_retire", ret_a, 0);

        // affine step on the saturating core, wrapping add on the other
        rom_a[0] = ins(OP_LSW, 0);  rom_a[1] = ins(OP_MULI, 3);
        rom_a[2] = ins(OP_OUT, 0);  rom_a[3] = ins(OP_HALT, 0);
        rom_b[0] = ins(OP_LSW, 0);  rom_b[1] = ins(OP_ADDI, 15);
        rom_b[2] = ins(OP_OUT, 0);  rom_b[3] = ins(OP_HALT, 0);
        sw_a = 8'd40; sw_b = 8'd120;
        restart();
        go_to(8);  chk("affine_led_c8", led_a, 0);
        go_to(9);  chk("affine_led_c9", led_a, 30);
        go_to(11); chk("affine_halt_c11", halted_a, 0);
        go_to(12); chk("affine_halt_c12", halted_a, 1);
        go_to(20);
        chk("affine_retires", rc_a, 4);
        chk("affine_pc_frozen", pa_a, 3);
        chk("affine_ovf", ovf_a, 0);
        chk("wrap_add_led", led_b, 135);
        chk("wrap_add_ovf", ovf_b, 1);

        // saturating add
        fill();
        rom_a[0] = ins(OP_LSW, 0);  rom_a[1] = ins(OP_ADDI, 15);
        rom_a[2] = ins(OP_OUT, 0);  rom_a[3] = ins(OP_HALT, 0);
        sw_a = 8'd120;
        restart();
        go_to(20);
        chk("sat_add_led", led_a, 127);
        chk("sat_add_ovf", ovf_a, 1);

        // register multiply saturation; floor rounding of a small negative product
        fill();
        rom_a[0] = ins(OP_LSW, 0);  rom_a[1] = ins(OP_ATR, 0);
        rom_a[2] = ins(OP_MUL, 0);  rom_a[3] = ins(OP_OUT, 0);
        rom_b[0] = ins(OP_LSW, 0);  rom_b[1] = ins(OP_MULI, -2);
        rom_b[2] = ins(OP_OUT, 0);
        sw_a = 8'd127; sw_b = 8'd1;
        restart();
        go_to(20);
        chk("sat_mul_led", led_a, 127);
        chk("sat_mul_ovf", ovf_a, 1);
        chk("floor_mul_led", led_b, 255);
        chk("floor_mul_ovf", ovf_b, 0);

        // negative immediate multiply
        fill();
        rom_a[0] = ins(OP_LSW, 0);  rom_a[1] = ins(OP_MULI, -2);
        rom_a[2] = ins(OP_OUT, 0);
        sw_a = 8'd40;
        restart();
        go_to(20);
        chk("muli_neg_led", led_a, 236);
        chk("muli_neg_ovf", ovf_a, 0);

        // countdown loop: BNZ taken twice, nine retirements
        fill();
        rom_a[0] = ins(OP_LSW, 0);  rom_a[1] = ins(OP_ADDI, -1);
        rom_a[2] = ins(OP_BNZ, 1);  rom_a[3] = ins(OP_OUT, 0);
        rom_a[4] = ins(OP_HALT, 0);
        sw_a = 8'd3;
        restart();
        go_to(26); chk("loop_halt_c26", halted_a, 0);
        go_to(27); chk("loop_halt_c27", halted_a, 1);
        go_to(32);
        chk("loop_retires", rc_a, 9);
        chk("loop_led", led_a, 0);
        chk("loop_ovf", ovf_a, 0);

        // HEI handshake
        fill();
        rom_a[0] = ins(OP_HEI, 1);  rom_a[1] = ins(OP_ADDI, 5);
        rom_a[2] = ins(OP_OUT, 0);
        go_a = 1'b0;
        restart();
        go_to(2);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (pa_a !== 5'd0 || halted_a !== 1'b0) bad++;
        end
        chk("hei_hold_pc", bad, 0);
        chk("hei_hold_retire", rc_a, 0);
        go_a = 1'b1;
        k = 0;
        while (k < 3 && ret_a !== 1'b1) begin
            cyc();
            k++;
        end
        chk("hei_retire_seen", ret_a, 1);
        cyc();
        chk("hei_pc_advance", pa_a, 1);
        go_to(cyc_n + 12);
        chk("hei_led", led_a, 5);
        go_a = 1'b0;

        // asynchronous reset during EXEC of ATR
        fill();
        rom_a[0] = ins(OP_LSW, 0);  rom_a[1] = ins(OP_ADDI, 15);
        rom_a[2] = ins(OP_OUT, 0);  rom_a[3] = ins(OP_ATR, 0);
        sw_a = 8'd120;
        restart();
        go_to(11);
        chk("pre_rst_ovf", ovf_a, 1);
        chk("pre_rst_led", led_a, 127);
        chk("pre_rst_retire", ret_a, 1);
        nReset = 1'b0;
        #1;
        chk("mid_rst_addr", pa_a, 0);
        chk("mid_rst_led", led_a, 0);
        chk("mid_rst_ovf", ovf_a, 0);
        chk("mid_rst_retire", ret_a, 0);
        fill();
        rom_a[0] = ins(OP_ADDI, 1); rom_a[1] = ins(OP_OUT, 0);
        rom_a[2] = ins(OP_RTA, 0);  rom_a[3] = ins(OP_ADDI, 2);
        rom_a[4] = ins(OP_OUT, 0);
        restart();
        go_to(6);  chk("post_rst_acc", led_a, 1);
        go_to(25);
        chk("post_rst_reg0", led_a, 2);
        chk("post_rst_halted", halted_a, 1);

        // PC wrap on the 3-bit core; BNEG taken on the default core
        fill();
        for (int i = 0; i < 7; i++) rom_b[i] = ins(OP_NOP, 0);
        rom_b[7] = ins(OP_JMP, 0);
        rom_a[0] = ins(OP_LSW, 0);  rom_a[1] = ins(OP_BNEG, 5);
        rom_a[2] = ins(OP_ADDI, 9); rom_a[3] = ins(OP_OUT, 0);
        rom_a[4] = ins(OP_HALT, 0); rom_a[5] = ins(OP_ADDI, 5);
        rom_a[6] = ins(OP_OUT, 0);  rom_a[7] = ins(OP_HALT, 0);
        sw_a = 8'd255;
        restart();
        for (int i = 0; i <= 8; i++) begin
            go_to(3 * i);
            chk("wrap_fetch_addr", pa_b, i % 8);
        end
        chk("bneg_taken_led", led_a, 4);
        chk("bneg_taken_pc", pa_a, 7);
        sw_a = 8'd0;
        restart();
        go_to(24);
        chk("bneg_fall_led", led_a, 9);
        chk("bneg_fall_pc", pa_a, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
